mem_bus_arbiter: RTL and testbench

Sequences main-memory accesses for the ARC datapath and shares a single memory port between two requesters: the microcoded CPU (read/write bits of the current microinstruction) and an I/O/DMA port. It sits between the control section and the memory. It produces the `ack` that holds the control section on the current microinstruction until the access completes. A cycle timeout protects the CPU from a memory that never acknowledges.

---
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the microcoded CPU and an I/O/DMA port, with round-robin arbitration and an access timeout.
// Latency: grant to mem_req is 1 cycle, mem_ack to done pulse is 1 cycle. Requesters hold their level requests until their done pulse.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic                owner_q, owner_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;

  logic cpu_req;
  logic gnt_io;

  assign cpu_req = cpu_rd | cpu_wr;
  // On contention the I/O port wins only if the CPU was served last.
  assign gnt_io  = io_req & (~cpu_req | (last_gnt_q == OWN_CPU));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          state_d    = ACCESS;
          cnt_d      = '0;
          err_d      = 1'b0;
          owner_d    = gnt_io ? OWN_IO : OWN_CPU;
          last_gnt_d = gnt_io ? OWN_IO : OWN_CPU;
          if (gnt_io) begin
            mem_we_d    = io_we;
            mem_addr_d  = io_addr;
            mem_wdata_d = io_wdata;
          end else begin
            // A read and a write bit together resolve to a read.
            mem_we_d    = cpu_wr & ~cpu_rd;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
          if (owner_q == OWN_IO) io_rdata_d = mem_rdata;
          else                   cpu_rdata_d = mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q == OWN_IO) io_rdata_d = '0;
          else                   cpu_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= OWN_IO;
      owner_q     <= OWN_CPU;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;
  assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
  assign io_done   = (state_q == RESP) && (owner_q == OWN_IO);
  assign bus_err   = (state_q == RESP) && err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT=4; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        io_req, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_done;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        bus_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_done(io_done), .io_rdata(io_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t_prev;

  initial begin
    rst = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_io_done", 32'(io_done), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_io_rdata", io_rdata, 0);
    rst = 1'b0;
    tick();

    // Stray mem_ack in IDLE is ignored
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_cpu_ack", 32'(cpu_ack), 0);
    chk("stray_cpu_rdata", cpu_rdata, 0);
    mem_ack = 0;

    // CPU-only read, ack in the 3rd ACCESS cycle
    cpu_rd = 1; cpu_addr = 32'h100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("rd_mem_req_c%0d", i), 32'(mem_req), 1);
      chk($sformatf("rd_io_done_c%0d", i), 32'(io_done), 0);
    end
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", mem_addr, 32'h100);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_cpu_ack", 32'(cpu_ack), 1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_mem_req_resp", 32'(mem_req), 0);
    chk("rd_io_done", 32'(io_done), 0);
    chk("rd_bus_err", 32'(bus_err), 0);
    mem_ack = 0; cpu_rd = 0;
    tick();
    chk("rd_ack_width", 32'(cpu_ack), 0);
    chk("rd_idle", 32'(busy), 0);
    chk("rd_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

    // Contention from reset: CPU, IO, CPU, IO, 3 cycles apart
    rst = 1;
    cpu_wr = 1; cpu_addr = 32'hA0; cpu_wdata = 32'h11;
    io_req = 1; io_we = 1; io_addr = 32'hB0; io_wdata = 32'h22;
    tick();
    chk("rst_cpu_rdata_clr", cpu_rdata, 0);
    rst = 0;
    tick();
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_mem_req_%0d", i), 32'(mem_req), 1);
      chk($sformatf("cont_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      chk($sformatf("cont_wdata_%0d", i), mem_wdata, (i % 2 == 0) ? 32'h11 : 32'h22);
      chk($sformatf("cont_we_%0d", i), 32'(mem_we), 1);
      mem_ack = 1; mem_rdata = 32'h1000 + 32'(i);
      tick();
      chk($sformatf("cont_cpu_ack_%0d", i), 32'(cpu_ack), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_io_done_%0d", i), 32'(io_done), (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) chk($sformatf("cont_cpu_rdata_%0d", i), cpu_rdata, 32'h1000 + 32'(i));
      else            chk($sformatf("cont_io_rdata_%0d", i), io_rdata, 32'h1000 + 32'(i));
      if (i > 0) chk($sformatf("cont_period_%0d", i), 32'(cyc - t_prev), 3);
      t_prev = cyc;
      mem_ack = 0;
      if (i == 3) begin
        cpu_wr = 0; io_req = 0;
      end
      tick();
      chk($sformatf("cont_idle_%0d", i), 32'(busy), 0);
      tick();
    end
    chk("cont_final_idle", 32'(busy), 0);

    // Timeout on an IO read; request dropped mid-access is ignored
    io_req = 1; io_we = 0; io_addr = 32'h30;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_mem_req_c%0d", i), 32'(mem_req), 1);
      chk($sformatf("to_io_done_c%0d", i), 32'(io_done), 0);
      io_req = 0;
    end
    tick();
    chk("to_io_done", 32'(io_done), 1);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_io_rdata", io_rdata, 0);
    chk("to_cpu_ack", 32'(cpu_ack), 0);
    chk("to_mem_req_resp", 32'(mem_req), 0);
    tick();
    chk("to_idle", 32'(busy), 0);
    chk("to_err_width", 32'(bus_err), 0);

    // Ack on the timeout cycle wins
    cpu_rd = 1; cpu_addr = 32'h40;
    for (int i = 1; i <= 4; i++) tick();
    chk("ackto_mem_req_c4", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h5A;
    tick();
    chk("ackto_cpu_ack", 32'(cpu_ack), 1);
    chk("ackto_bus_err", 32'(bus_err), 0);
    chk("ackto_cpu_rdata", cpu_rdata, 32'h5A);
    mem_ack = 0; cpu_rd = 0;
    tick();
    chk("ackto_idle", 32'(busy), 0);

    // Requester inputs change during ACCESS
    cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'h77;
    tick();
    chk("chg_addr_c1", mem_addr, 32'h10);
    cpu_addr = 32'h20; cpu_wr = 0; cpu_wdata = 32'h88;
    tick();
    chk("chg_addr_c2", mem_addr, 32'h10);
    chk("chg_we_c2", 32'(mem_we), 1);
    chk("chg_wdata_c2", mem_wdata, 32'h77);
    chk("chg_mem_req_c2", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h0;
    tick();
    chk("chg_cpu_ack", 32'(cpu_ack), 1);
    mem_ack = 0;
    tick();
    chk("chg_idle", 32'(busy), 0);

    // Reset in the 2nd ACCESS cycle, then CPU wins over the pending IO
    io_req = 1; io_we = 0; io_addr = 32'h50;
    tick();
    chk("rmid_mem_addr", mem_addr, 32'h50);
    tick();
    chk("rmid_mem_req_c2", 32'(mem_req), 1);
    rst = 1; cpu_rd = 1; cpu_addr = 32'h60;
    tick();
    chk("rmid_mem_req", 32'(mem_req), 0);
    chk("rmid_io_done", 32'(io_done), 0);
    chk("rmid_cpu_ack", 32'(cpu_ack), 0);
    chk("rmid_bus_err", 32'(bus_err), 0);
    chk("rmid_busy", 32'(busy), 0);
    rst = 0;
    tick();
    chk("rmid_gnt_cpu", mem_addr, 32'h60);
    chk("rmid_gnt_we", 32'(mem_we), 0);
    mem_ack = 1; mem_rdata = 32'h66;
    tick();
    chk("rmid_cpu_ack2", 32'(cpu_ack), 1);
    chk("rmid_io_done2", 32'(io_done), 0);
    mem_ack = 0; cpu_rd = 0;
    tick();
    tick();
    chk("rmid_gnt_io", mem_addr, 32'h50);
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    chk("rmid_io_done3", 32'(io_done), 1);
    chk("rmid_io_rdata", io_rdata, 32'h55);
    mem_ack = 0; io_req = 0;
    tick();
    chk("rmid_final_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
